fb_run_reader: RTL and testbench
================================

Name: fb_run_reader

Overview:
- Read-side client of the 1-bit binarized frame buffer. The writer side stores pixels at address x + WIDTH*y.
- On a start pulse, scans the stored frame in raster order through a second BRAM port and compresses each row into run-length tokens (colour, length, start x, y).
- Tokens leave on a valid/ready stream that feeds the downstream QR finder-pattern detector.
- Tolerates the BRAM's fixed read latency and arbitrary downstream backpressure without losing or duplicating pixels.

Parameters:
- WIDTH, 640, pixels per stored row.
- HEIGHT, 480, rows per stored frame.
- READ_LATENCY, 2, BRAM address-to-data latency in cycles (output register enabled).
- FIFO_DEPTH, 4, pixel skid-FIFO entries; must be >= READ_LATENCY+1.

Ports:
- clk_in  input  1  system clock (clk_pixel domain)
- rst_in  input  1  synchronous active-high reset
- start_in  input  1  single-cycle pulse: begin scanning a frame
- busy_out  output  1  high from accepted start until frame_done_out
- bram_addr_out  output  $clog2(WIDTH*HEIGHT)  read address to frame buffer port
- bram_en_out  output  1  read enable; high only in cycles that issue a read
- bram_data_in  input  1  read data, valid READ_LATENCY cycles after an enabled read
- run_valid_out  output  1  token valid
- run_ready_in  input  1  consumer accepts token when valid&&ready
- run_color_out  output  1  pixel value of the run
- run_len_out  output  $clog2(WIDTH+1)  run length, 1..WIDTH
- run_x_out  output  $clog2(WIDTH)  x of first pixel in run
- run_y_out  output  $clog2(HEIGHT)  row of run
- run_eol_out  output  1  run ends at x=WIDTH-1
- frame_done_out  output  1  single-cycle pulse after last token of frame is accepted

Behaviour:
- Reset: FSM=IDLE; all counters, FIFO, in-flight tracking cleared.
- Reset values: busy_out=0, bram_en_out=0, bram_addr_out=0, run_valid_out=0, run_* data=0, run_eol_out=0, frame_done_out=0.
- FSM states:
  - IDLE: start_in -> SCAN; clear read x/y, address, accumulator.
  - SCAN: issue reads. After address WIDTH*HEIGHT-1 is issued -> DRAIN.
  - DRAIN: no reads. When in-flight=0, FIFO empty, accumulator empty and token accepted -> DONE.
  - DONE: one cycle; frame_done_out=1 -> IDLE.
- start_in outside IDLE is ignored; the current scan continues unchanged.
- Read issue:
  - A read is issued only when inflight_count + fifo_count < FIFO_DEPTH, so returning data always has space.
  - Address increments by 1 per issued read; the read-side x/y counters wrap x at WIDTH-1 to 0 and increment y.
  - A READ_LATENCY-deep valid shift register marks returning data and pushes it into the FIFO.
- Run accumulator (cur_color, cur_len, cur_x, y):
  - Pops one FIFO pixel per cycle when it can proceed.
  - Pixel equals cur_color and is not the first pixel of a row: cur_len += 1.
  - Otherwise the current run closes into the output register and a new run starts with len=1.
  - A run also closes on the last pixel of a row (x=WIDTH-1), with eol=1. Runs never cross rows.
  - Closing requires the output register to be empty or being accepted this cycle. Otherwise the pop stalls, the FIFO fills, and reads stop.
- Output stream:
  - Registered. Once run_valid_out rises, all run_* values hold until accepted.
  - Accept and load in the same cycle is allowed: no bubble, one token per cycle at most.
- Throughput: one pixel per cycle with run_ready_in held high.
- Arithmetic:
  - run_len is unsigned and saturates nowhere; max WIDTH is fits by width choice.
  - Address is x + WIDTH*y. Maintained by increment, not multiply.
- Reset mid-scan: aborts immediately to reset values. Late BRAM data is discarded because the valid shift register is cleared.
- Token count per row is >=1 and sum of run_len per row == WIDTH.

Decomposition:
- Package fb_reader_pkg:
  - state enum {IDLE, SCAN, DRAIN, DONE}
  - run token struct {color, len, x, y, eol}
  - width localparams derived from WIDTH/HEIGHT
- Sub-module: sync_fifo (parameterized width/depth, count output) for the pixel skid buffer. Everything else stays inline.

Test Plan:
- WIDTH=8, HEIGHT=2, all-zero memory, ready=1, start -> exactly 2 tokens: (c0,len8,x0,y0,eol1), (c0,len8,x0,y1,eol1); frame_done pulse 1 cycle after second accept; busy drops same cycle.
- Row 0 = 1,0,1,1,1,0,1,1 (WIDTH=8) -> tokens (1,1,x0),(0,1,x1),(1,3,x2),(0,1,x5),(1,2,x6,eol1).
- Row 0 = 0,1,0,1 ... (alternating), ready low 20 cycles after first valid -> token held stable, bram_en_out deasserts within FIFO_DEPTH reads; all 8 tokens eventually emitted in order, none dropped.
- Random ready (50%), random 640x480 image -> per row, token lens sum to 640 and reconstructed bits match memory model.
- rst_in for 1 cycle mid-row 3 -> all outputs at reset values the next cycle; a following start yields a full correct scan from y=0.
- start_in pulsed again during SCAN -> ignored; token sequence is identical to the single-start run.

Source files
------------

// File: rtl/fb_run_reader_pkg.sv
// Shared types and helpers for the frame-buffer run-length reader.
// Token fields are sized for the largest supported frame so consumers can share one type.
package fb_reader_pkg;

  localparam int DEF_WIDTH   = 640;
  localparam int DEF_HEIGHT  = 480;
  localparam int TOK_FIELD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic                   color;
    logic [TOK_FIELD_W-1:0] len;
    logic [TOK_FIELD_W-1:0] x;
    logic [TOK_FIELD_W-1:0] y;
    logic                   eol;
  } run_token_t;

  // Bits needed to index n items, never less than one.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fb_run_reader_sync_fifo.sv
// Small first-word-fall-through FIFO with occupancy count, used as the pixel skid buffer.
// Push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo
  import fb_reader_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int DEPTH  = 4,
  localparam int PTR_W = cnt_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              wr_en;
  logic              rd_en;

  assign rd_en    = pop && (count_reg != '0);
  assign wr_en    = push && ((count_reg < CNT_W'(DEPTH)) || rd_en);
  assign pop_data = mem_reg[rd_ptr_reg];
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (rd_en) begin
        rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/fb_run_reader.sv
// Scans a 1-bit frame buffer in raster order and emits per-row run-length tokens
// on a valid/ready stream, absorbing BRAM latency and downstream backpressure.
module fb_run_reader
  import fb_reader_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int HEIGHT       = DEF_HEIGHT,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_W = cnt_w(WIDTH * HEIGHT),
  localparam int LEN_W  = cnt_w(WIDTH + 1),
  localparam int X_W    = cnt_w(WIDTH),
  localparam int Y_W    = cnt_w(HEIGHT),
  localparam int CNT_W  = cnt_w(FIFO_DEPTH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start_in,
  output logic              busy_out,
  output logic [ADDR_W-1:0] bram_addr_out,
  output logic              bram_en_out,
  input  logic              bram_data_in,
  output logic              run_valid_out,
  input  logic              run_ready_in,
  output logic              run_color_out,
  output logic [LEN_W-1:0]  run_len_out,
  output logic [X_W-1:0]    run_x_out,
  output logic [Y_W-1:0]    run_y_out,
  output logic              run_eol_out,
  output logic              frame_done_out
);

  state_t state_reg, state_next;
  logic   start_scan;

  logic [ADDR_W-1:0]       addr_reg;
  logic [X_W-1:0]          rd_x_reg;
  logic [Y_W-1:0]          rd_y_reg;
  logic [READ_LATENCY-1:0] vld_sr_reg;
  logic [READ_LATENCY-1:0] vld_sr_next;
  logic [CNT_W-1:0]        inflight;
  logic [CNT_W:0]          occupancy;
  logic                    room;
  logic                    issue;
  logic                    last_addr;

  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_pixel;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic [X_W-1:0]   pop_x_reg;
  logic [Y_W-1:0]   pop_y_reg;
  logic             acc_valid_reg;
  logic             acc_closed_reg;
  logic             cur_color_reg;
  logic [LEN_W-1:0] cur_len_reg;
  logic [X_W-1:0]   cur_x_reg;
  logic [Y_W-1:0]   cur_y_reg;

  logic             out_valid_reg;
  logic             out_color_reg;
  logic [LEN_W-1:0] out_len_reg;
  logic [X_W-1:0]   out_x_reg;
  logic [Y_W-1:0]   out_y_reg;
  logic             out_eol_reg;

  logic can_out;
  logic accept;
  logic need_emit;
  logic flush;
  logic load;
  logic pop_last_x;

  // ---------------- read issue ----------------
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_sr_reg[i]);
    end
  end

  // Reads are throttled so every returning pixel is guaranteed a FIFO slot.
  assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
  assign room      = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue     = (state_reg == SCAN) && room;
  assign last_addr = (rd_x_reg == X_W'(WIDTH - 1)) && (rd_y_reg == Y_W'(HEIGHT - 1));

  generate
    if (READ_LATENCY == 1) begin : g_vld_one
      assign vld_sr_next = issue;
    end else begin : g_vld_multi
      assign vld_sr_next = {vld_sr_reg[READ_LATENCY-2:0], issue};
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      vld_sr_reg <= '0;
    end else begin
      vld_sr_reg <= vld_sr_next;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || start_scan) begin
      addr_reg <= '0;
      rd_x_reg <= '0;
      rd_y_reg <= '0;
    end else if (issue) begin
      addr_reg <= addr_reg + 1'b1;
      if (rd_x_reg == X_W'(WIDTH - 1)) begin
        rd_x_reg <= '0;
        rd_y_reg <= rd_y_reg + 1'b1;
      end else begin
        rd_x_reg <= rd_x_reg + 1'b1;
      end
    end
  end

  assign fifo_push = vld_sr_reg[READ_LATENCY-1];

  sync_fifo #(
    .DATA_W (1),
    .DEPTH  (FIFO_DEPTH)
  ) u_pixel_fifo (
    .clk       (clk_in),
    .rst       (rst_in),
    .clr       (start_scan),
    .push      (fifo_push),
    .push_data (bram_data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_pixel),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // ---------------- run accumulator ----------------
  // A run finished at end of row is held "closed" and emitted by the next pop
  // (or flushed when idle), so each cycle produces at most one token.
  assign accept     = out_valid_reg && run_ready_in;
  assign can_out    = !out_valid_reg || run_ready_in;
  assign need_emit  = acc_valid_reg && (acc_closed_reg || (fifo_pixel != cur_color_reg));
  assign fifo_pop   = !fifo_empty && (!need_emit || can_out);
  assign flush      = !fifo_pop && acc_valid_reg && acc_closed_reg && can_out;
  assign load       = (fifo_pop && need_emit) || flush;
  assign pop_last_x = (pop_x_reg == X_W'(WIDTH - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in || start_scan) begin
      pop_x_reg      <= '0;
      pop_y_reg      <= '0;
      acc_valid_reg  <= 1'b0;
      acc_closed_reg <= 1'b0;
      cur_color_reg  <= 1'b0;
      cur_len_reg    <= '0;
      cur_x_reg      <= '0;
      cur_y_reg      <= '0;
    end else if (fifo_pop) begin
      if (pop_last_x) begin
        pop_x_reg <= '0;
        pop_y_reg <= pop_y_reg + 1'b1;
      end else begin
        pop_x_reg <= pop_x_reg + 1'b1;
      end
      acc_valid_reg  <= 1'b1;
      acc_closed_reg <= pop_last_x;
      if (need_emit || !acc_valid_reg) begin
        cur_color_reg <= fifo_pixel;
        cur_len_reg   <= LEN_W'(1);
        cur_x_reg     <= pop_x_reg;
        cur_y_reg     <= pop_y_reg;
      end else begin
        cur_len_reg <= cur_len_reg + 1'b1;
      end
    end else if (flush) begin
      acc_valid_reg  <= 1'b0;
      acc_closed_reg <= 1'b0;
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_valid_reg <= 1'b0;
      out_color_reg <= 1'b0;
      out_len_reg   <= '0;
      out_x_reg     <= '0;
      out_y_reg     <= '0;
      out_eol_reg   <= 1'b0;
    end else if (load) begin
      out_valid_reg <= 1'b1;
      out_color_reg <= cur_color_reg;
      out_len_reg   <= cur_len_reg;
      out_x_reg     <= cur_x_reg;
      out_y_reg     <= cur_y_reg;
      out_eol_reg   <= acc_closed_reg;
    end else if (accept) begin
      out_valid_reg <= 1'b0;
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    start_scan = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_in) begin
          state_next = SCAN;
          start_scan = 1'b1;
        end
      end
      SCAN: begin
        if (issue && last_addr) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // Everything drained and the final token leaves this cycle.
        if ((inflight == '0) && fifo_empty && !acc_valid_reg && accept && !load) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy_out       = (state_reg == SCAN) || (state_reg == DRAIN);
  assign frame_done_out = (state_reg == DONE);
  assign bram_en_out    = issue;
  assign bram_addr_out  = addr_reg;
  assign run_valid_out  = out_valid_reg;
  assign run_color_out  = out_color_reg;
  assign run_len_out    = out_len_reg;
  assign run_x_out      = out_x_reg;
  assign run_y_out      = out_y_reg;
  assign run_eol_out    = out_eol_reg;

endmodule

// File: tb/tb_fb_run_reader.sv
// Scoreboard bench for fb_run_reader on an 8x4 frame with a 2-cycle BRAM model.
// Stimulus pushes expected tokens; a negedge monitor pops and compares on each handshake.
module tb_fb_run_reader;
  import fb_reader_pkg::*;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int N     = W * H;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic       start_in = 1'b0;
  logic       busy_out;
  logic [4:0] bram_addr_out;
  logic       bram_en_out;
  logic       bram_data_in;
  logic       run_valid_out;
  logic       run_ready_in = 1'b1;
  logic       run_color_out;
  logic [3:0] run_len_out;
  logic [2:0] run_x_out;
  logic [1:0] run_y_out;
  logic       run_eol_out;
  logic       frame_done_out;

  fb_run_reader #(
    .WIDTH        (W),
    .HEIGHT       (H),
    .READ_LATENCY (LAT),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .busy_out       (busy_out),
    .bram_addr_out  (bram_addr_out),
    .bram_en_out    (bram_en_out),
    .bram_data_in   (bram_data_in),
    .run_valid_out  (run_valid_out),
    .run_ready_in   (run_ready_in),
    .run_color_out  (run_color_out),
    .run_len_out    (run_len_out),
    .run_x_out      (run_x_out),
    .run_y_out      (run_y_out),
    .run_eol_out    (run_eol_out),
    .frame_done_out (frame_done_out)
  );

  always #5 clk = ~clk;

  // BRAM model: address registered, then output register -> two-cycle latency.
  logic mem [N];
  logic bram_r1 = 1'b0;
  logic bram_r2 = 1'b0;
  always @(posedge clk) begin
    if (bram_en_out) bram_r1 <= mem[bram_addr_out];
    bram_r2 <= bram_r1;
  end
  assign bram_data_in = bram_r2;

  // 0: ready high, 1: random ready, 2: ready held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       run_ready_in = 1'b1;
      1:       run_ready_in = 1'($urandom_range(0, 1));
      default: run_ready_in = 1'b0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;
  int done_count = 0;
  run_token_t exp_q[$];

  function automatic run_token_t mk(input logic c, input int l, input int x, input int y,
                                    input logic e);
    run_token_t t;
    t.color = c;
    t.len   = 16'(l);
    t.x     = 16'(x);
    t.y     = 16'(y);
    t.eol   = e;
    return t;
  endfunction

  // Reference runs straight from the memory image.
  function automatic void push_model();
    for (int y = 0; y < H; y++) begin
      int x0 = 0;
      for (int x = 0; x < W; x++) begin
        if (x == W - 1 || mem[y*W+x+1] != mem[y*W+x]) begin
          exp_q.push_back(mk(mem[y*W+x], x - x0 + 1, x0, y, x == W - 1));
          x0 = x + 1;
        end
      end
    end
  endfunction

  // ---------------- monitor ----------------
  initial begin
    run_token_t act;
    run_token_t held;
    run_token_t exp_t;
    bit hold_pending = 0;
    bit expect_done = 0;
    forever begin
      @(negedge clk);
      if (rst_in) begin
        hold_pending = 0;
        expect_done  = 0;
      end else begin
        if (expect_done) begin
          n_cmp++;
          if (!(frame_done_out && !busy_out)) begin
            n_bad++;
            $display("FAIL frame_done: done=%0b busy=%0b, required done=1 busy=0",
                     frame_done_out, busy_out);
          end
          expect_done = 0;
        end else if (frame_done_out) begin
          n_cmp++;
          n_bad++;
          $display("FAIL frame_done: pulse seen=1, required 0 (tokens pending=%0d)", exp_q.size());
        end
        if (frame_done_out) done_count++;
        act = mk(run_color_out, int'(run_len_out), int'(run_x_out), int'(run_y_out), run_eol_out);
        if (hold_pending) begin
          n_cmp++;
          if (!run_valid_out || act != held) begin
            n_bad++;
            $display("FAIL hold: valid=%0b c=%0b len=%0d x=%0d y=%0d eol=%0b, required held c=%0b len=%0d x=%0d y=%0d eol=%0b",
                     run_valid_out, act.color, act.len, act.x, act.y, act.eol,
                     held.color, held.len, held.x, held.y, held.eol);
          end
        end
        hold_pending = run_valid_out && !run_ready_in;
        held = act;
        if (run_valid_out && run_ready_in) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL token: got c=%0b len=%0d x=%0d y=%0d eol=%0b, required none",
                     act.color, act.len, act.x, act.y, act.eol);
          end else begin
            exp_t = exp_q.pop_front();
            if (act != exp_t) begin
              n_bad++;
              $display("FAIL token: got c=%0b len=%0d x=%0d y=%0d eol=%0b, required c=%0b len=%0d x=%0d y=%0d eol=%0b",
                       act.color, act.len, act.x, act.y, act.eol,
                       exp_t.color, exp_t.len, exp_t.x, exp_t.y, exp_t.eol);
            end else begin
              $display("token ok c=%0b len=%0d x=%0d y=%0d eol=%0b",
                       act.color, act.len, act.x, act.y, act.eol);
            end
            if (exp_q.size() == 0) expect_done = 1;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    logic [19:0] v;
    v = {busy_out, bram_en_out, bram_addr_out, run_valid_out, run_color_out,
         run_len_out, run_x_out, run_y_out, run_eol_out, frame_done_out};
    n_cmp++;
    if (v != '0) begin
      n_bad++;
      $display("FAIL %s: outputs=%h, required 0", name, v);
    end else begin
      $display("%s outputs at reset values", name);
    end
  endtask

  task automatic wait_done(input string name);
    int c = 0;
    int d0 = done_count;
    while (done_count == d0 && c < 1000) begin
      tick(1);
      c++;
    end
    n_cmp++;
    if (done_count == d0) begin
      n_bad++;
      $display("FAIL %s: no frame_done within %0d cycles, required one", name, c);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: %0d tokens missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  initial begin
    int c;
    int reads;
    int d0;
    logic row0 [W];

    tick(3);
    check_reset_outputs("reset_hold");
    rst_in = 1'b0;
    tick(1);
    check_reset_outputs("reset_idle");

    // all-zero frame: one full-row token per row
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
    for (int y = 0; y < H; y++) exp_q.push_back(mk(1'b0, W, 0, y, 1'b1));
    start_pulse();
    wait_done("zero_frame");

    // row 0 = 1,0,1,1,1,0,1,1 ; remaining rows zero
    row0 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < N; i++) mem[i] = 1'b0;
    for (int x = 0; x < W; x++) mem[x] = row0[x];
    exp_q.push_back(mk(1'b1, 1, 0, 0, 1'b0));
    exp_q.push_back(mk(1'b0, 1, 1, 0, 1'b0));
    exp_q.push_back(mk(1'b1, 3, 2, 0, 1'b0));
    exp_q.push_back(mk(1'b0, 1, 5, 0, 1'b0));
    exp_q.push_back(mk(1'b1, 2, 6, 0, 1'b1));
    for (int y = 1; y < H; y++) exp_q.push_back(mk(1'b0, W, 0, y, 1'b1));
    start_pulse();
    wait_done("pattern_row");

    // alternating pixels with a 20-cycle stall after the first valid token
    for (int i = 0; i < N; i++) mem[i] = 1'((i % W) % 2);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) exp_q.push_back(mk(1'(x % 2), 1, x, y, x == W - 1));
    start_pulse();
    c = 0;
    while (!run_valid_out && c < 100) begin
      tick(1);
      c++;
    end
    ready_mode = 2;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (bram_en_out) reads++;
    end
    n_cmp++;
    if (reads > DEPTH) begin
      n_bad++;
      $display("FAIL stall_reads: reads=%0d, required <= %0d", reads, DEPTH);
    end
    n_cmp++;
    if (bram_en_out !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_en: bram_en=%0b, required 0", bram_en_out);
    end
    ready_mode = 0;
    wait_done("stall_alt");

    // random image with random backpressure
    for (int i = 0; i < N; i++) mem[i] = 1'($urandom_range(0, 1));
    push_model();
    ready_mode = 1;
    start_pulse();
    wait_done("random_ready");
    ready_mode = 0;

    // reset in the middle of row 3, then a clean rescan
    for (int i = 0; i < N; i++) mem[i] = 1'($urandom_range(0, 1));
    push_model();
    start_pulse();
    c = 0;
    while (!(bram_en_out && bram_addr_out == 5'(3 * W + 4)) && c < 200) begin
      tick(1);
      c++;
    end
    rst_in = 1'b1;
    exp_q.delete();
    tick(1);
    rst_in = 1'b0;
    check_reset_outputs("reset_midscan");
    push_model();
    start_pulse();
    wait_done("after_reset");

    // second start during SCAN must be ignored
    for (int i = 0; i < N; i++) mem[i] = 1'($urandom_range(0, 1));
    push_model();
    ready_mode = 1;
    d0 = done_count;
    start_pulse();
    tick(4);
    start_pulse();
    wait_done("double_start");
    tick(20);
    n_cmp++;
    if (done_count != d0 + 1 || busy_out) begin
      n_bad++;
      $display("FAIL double_start_done: done pulses=%0d busy=%0b, required 1 busy=0",
               done_count - d0, busy_out);
    end
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
